// File: rtl/au_div_seq_if.sv
// Request/result handshake bundle for the sequential divider.
// The master issues operands and consumes results; the slave is the divider.
interface au_div_seq_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start_valid, dividend, divisor, done_ready,
    input  start_ready, done_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start_valid, dividend, divisor, done_ready,
    output start_ready, done_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/au_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle through a single
// WIDTH+1-bit prefix subtractor whose carry network is selected by ARCH.
module au_div_seq #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  au_div_seq_if.slave  div_if
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // a - b as a + ~b + 1; ARCH 0 ripple, 1 Kogge-Stone, 2 Sklansky prefix.
  function automatic logic [N-1:0] au_sub(input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N-1:0] g, p, gp, pp, gn, pn, c;
    int           j;
    g  = a & ~b;
    p  = a ^ ~b;
    gp = g;
    pp = p;
    gp[0] = g[0] | p[0];
    gn = gp;
    pn = pp;
    j  = 0;
    if (ARCH == 1) begin
      for (int s = 1; s < N; s = s * 2) begin
        gn = gp;
        pn = pp;
        for (int i = s; i < N; i++) begin
          gn[i] = gp[i] | (pp[i] & gp[i-s]);
          pn[i] = pp[i] & pp[i-s];
        end
        gp = gn;
        pp = pn;
      end
    end else if (ARCH == 2) begin
      for (int s = 1; s < N; s = s * 2) begin
        gn = gp;
        pn = pp;
        for (int i = 0; i < N; i++) begin
          if ((i & s) != 0) begin
            j     = (i & ~(2 * s - 1)) | (s - 1);
            gn[i] = gp[i] | (pp[i] & gp[j]);
            pn[i] = pp[i] & pp[j];
          end
        end
        gp = gn;
        pp = pn;
      end
    end else begin
      for (int i = 1; i < N; i++) begin
        gp[i] = g[i] | (p[i] & gp[i-1]);
      end
    end
    c = {gp[N-2:0], 1'b1};
    return p ^ c;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic            dbz_q, dbz_d;

  logic            start_ready;
  logic            accept;
  logic [N-1:0]    trial;
  logic [N-1:0]    diff;

  // r < d always holds, so diff's MSB is an exact borrow flag.
  assign trial = {r_q, q_q[WIDTH-1]};
  assign diff  = au_sub(trial, {1'b0, d_q});

  assign start_ready = (state_q == S_IDLE) |
                       ((state_q == S_DONE) & div_if.done_ready);
  assign accept      = div_if.start_valid & start_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (!diff[WIDTH]) begin
          r_d = diff[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (div_if.done_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    // A new request overrides the DONE->IDLE step for bubble-free chaining.
    if (accept) begin
      q_d   = div_if.dividend;
      d_d   = div_if.divisor;
      r_d   = '0;
      cnt_d = CW'(WIDTH);
      if (div_if.divisor == '0) begin
        state_d = S_DONE;
        q_d     = '1;
        r_d     = div_if.dividend;
        dbz_d   = 1'b1;
      end else begin
        state_d = S_BUSY;
        dbz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_if.start_ready = start_ready;
  assign div_if.done_valid  = (state_q == S_DONE);
  assign div_if.quotient    = q_q;
  assign div_if.remainder   = r_q;
  assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_au_div_seq.sv
// Bench for au_div_seq: all three ARCH variants run in lockstep on shared
// stimulus and are compared against plain / and % arithmetic.
module tb_au_div_seq;

  localparam int W    = 8;
  localparam int NA   = 3;
  localparam int NOPS = 1500;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  logic          clk;
  logic          rst_n;
  logic          sv, dr;
  logic [W-1:0]  dd, dv;
  logic [NA-1:0] sr, dvld, dbz;
  logic [W-1:0]  quo [NA];
  logic [W-1:0]  rem [NA];

  int   errs = 0;
  int   nchk = 0;
  res_t sb[$];

  for (genvar a = 0; a < NA; a++) begin : g_arch
    au_div_seq_if #(.WIDTH(W)) bus ();
    assign bus.start_valid = sv;
    assign bus.dividend    = dd;
    assign bus.divisor     = dv;
    assign bus.done_ready  = dr;
    assign sr[a]   = bus.start_ready;
    assign dvld[a] = bus.done_valid;
    assign dbz[a]  = bus.div_by_zero;
    assign quo[a]  = bus.quotient;
    assign rem[a]  = bus.remainder;
    au_div_seq #(.WIDTH(W), .ARCH(a)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .div_if (bus.slave)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    if (b == 0) begin
      m.q = '1;
      m.r = a;
      m.z = 1'b1;
    end else begin
      m.q = W'(int'(a) / int'(b));
      m.r = W'(int'(a) % int'(b));
      m.z = 1'b0;
    end
    return m;
  endfunction

  task automatic chk_res(input string tag, input res_t e);
    for (int a = 0; a < NA; a++) begin
      chk($sformatf("%s_quo_a%0d", tag, a), quo[a], e.q);
      chk($sformatf("%s_rem_a%0d", tag, a), rem[a], e.r);
      chk($sformatf("%s_dbz_a%0d", tag, a), dbz[a], e.z);
    end
  endtask

  // Called at the negedge after the accepting posedge.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (dvld[0] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    chk({tag, "_ready_idle"}, sr, {NA{1'b1}});
    sv = 1'b1; dd = a; dv = b;
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0; dd = $urandom; dv = $urandom;
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, (b == 0) ? 1 : W + 1);
    chk({tag, "_dv_all"}, dvld, {NA{1'b1}});
    chk({tag, "_ready_done"}, sr, '0);
    chk_res(tag, model(a, b));
    dr = 1'b1;
    #1;
    chk({tag, "_ready_hs"}, sr, {NA{1'b1}});
    @(negedge clk);
    dr = 1'b0;
    chk({tag, "_dv_drop"}, dvld, '0);
  endtask

  initial begin
    int cyc;
    int sent, got, ncyc;
    res_t e;
    logic [W-1:0] ta [6] = '{8'd100, 8'd255, 8'd3,   8'd0, 8'd255, 8'd5};
    logic [W-1:0] tb [6] = '{8'd7,   8'd1,   8'd200, 8'd9, 8'd255, 8'd0};

    sv = 1'b0; dr = 1'b0; dd = '0; dv = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", sr, {NA{1'b1}});
    chk("rst_dv", dvld, '0);
    chk_res("rst", '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_op($sformatf("dir%0d", i), ta[i], tb[i]);

    // Result held under backpressure, then released with a chained request.
    sv = 1'b1; dd = 8'd100; dv = 8'd7;
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0;
    wait_done(cyc);
    chk("hold_latency", cyc, W + 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold_dv", dvld, {NA{1'b1}});
      chk("hold_ready", sr, '0);
      chk("hold_quo", quo[0], 8'd14);
      chk("hold_rem", rem[0], 8'd2);
    end
    dr = 1'b1; sv = 1'b1; dd = 8'd200; dv = 8'd3;
    #1;
    chk("chain_ready", sr, {NA{1'b1}});
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0; dr = 1'b0;
    chk("chain_dv_drop", dvld, '0);
    chk("chain_busy_ready", sr, '0);
    wait_done(cyc);
    chk("chain_latency", cyc, W + 1);
    chk_res("chain", model(8'd200, 8'd3));
    dr = 1'b1;
    @(negedge clk);
    dr = 1'b0;

    // Asynchronous abort in the middle of an iteration sequence.
    sv = 1'b1; dd = 8'd100; dv = 8'd7;
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_dv", dvld, '0);
    chk("abort_ready", sr, {NA{1'b1}});
    chk_res("abort", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_dv", dvld, '0);
    do_op("post_abort", 8'd17, 8'd5);

    // Random traffic with random valid/ready against a result queue.
    sent = 0; got = 0; ncyc = 0;
    while (got < NOPS && ncyc < 60000) begin
      dr = ($urandom_range(0, 3) != 0);
      sv = (sent < NOPS) && ($urandom_range(0, 3) != 0);
      dd = W'($urandom);
      case ($urandom_range(0, 9))
        0:       dv = '0;
        1:       dv = 8'd1;
        2:       dv = '1;
        3:       dv = W'($urandom_range(1, 15));
        default: dv = W'($urandom);
      endcase
      #1;
      if (sv && sr[0]) begin
        sb.push_back(model(dd, dv));
        sent++;
      end
      if (dvld[0] && dr) begin
        if (sb.size() == 0) begin
          chk("rand_spurious_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk_res("rand", e);
        end
        got++;
      end
      @(negedge clk);
      ncyc++;
    end
    sv = 1'b0; dr = 1'b0;
    chk("rand_results", got, NOPS);
    chk("rand_sent", sent, NOPS);
    chk("rand_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
